// File: rtl/blinds_motor_controller.sv
// Multi-channel blind motor controller: light hysteresis, manual override, dead-time reversal.
// Optional OVERRIDE_TIMEOUT_EN adds a per-channel override expiry timer.
module blinds_motor_controller #(
  parameter int NUM_CH       = 4,
  parameter int LIGHT_W      = 8,
  parameter int OPEN_TH      = 160,
  parameter int CLOSE_TH     = 96,
  parameter int TICK_DIV     = 1000,
  parameter int TRAVEL_TICKS = 50,
  parameter int DEAD_CYC     = 16,
  parameter int OVR_TICKS    = 3600,
  localparam int POS_W       = $clog2(TRAVEL_TICKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*LIGHT_W-1:0] light_level,
  input  logic [NUM_CH-1:0]         open_cmd,
  input  logic [NUM_CH-1:0]         close_cmd,
  input  logic [NUM_CH-1:0]         auto_resume,
  output logic [NUM_CH-1:0]         motor_up,
  output logic [NUM_CH-1:0]         motor_down,
  output logic [NUM_CH-1:0]         blinds_open,
  output logic [NUM_CH-1:0]         override,
  output logic [NUM_CH*POS_W-1:0]   position
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [POS_W-1:0] TOP = POS_W'(TRAVEL_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DEAD
  } state_t;

  if (CLOSE_TH >= OPEN_TH || OVR_TICKS < 1 || DEAD_CYC < 1 ||
      TICK_DIV < 1 || TRAVEL_TICKS < 1) begin : g_bad_cfg
    $error("blinds_motor_controller: invalid parameter set");
  end

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [LIGHT_W-1:0] light;
    logic               bright;
    logic               dark;
    logic               tgt_open;
    logic               ovr;
    logic               expire;
    state_t             st;
    state_t             st_nx;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   pos_nx;
    logic [DW-1:0]      dcnt;
    logic [DW-1:0]      dcnt_nx;

    assign light  = light_level[i*LIGHT_W +: LIGHT_W];
    assign bright = light > LIGHT_W'(OPEN_TH);
    assign dark   = light < LIGHT_W'(CLOSE_TH);

`ifdef OVERRIDE_TIMEOUT_EN
    localparam int TW = $clog2(OVR_TICKS + 1);
    logic [TW-1:0] tmr;

    assign expire = ovr && tick && (tmr <= TW'(1));

    always_ff @(posedge clk) begin
      if (rst || auto_resume[i]) begin
        tmr <= '0;
      end else if (open_cmd[i] || close_cmd[i]) begin
        tmr <= TW'(OVR_TICKS);
      end else if (ovr && tick && tmr != '0) begin
        tmr <= tmr - 1'b1;
      end
    end
`else
    assign expire = 1'b0;
`endif

    // Open beats close when both are pulsed together
    always_ff @(posedge clk) begin
      if (rst) begin
        tgt_open <= 1'b0;
        ovr      <= 1'b0;
      end else if (auto_resume[i]) begin
        ovr <= 1'b0;
      end else if (open_cmd[i]) begin
        tgt_open <= 1'b1;
        ovr      <= 1'b1;
      end else if (close_cmd[i]) begin
        tgt_open <= 1'b0;
        ovr      <= 1'b1;
      end else if (expire) begin
        ovr <= 1'b0;
      end else if (!ovr) begin
        if (bright) begin
          tgt_open <= 1'b1;
        end else if (dark) begin
          tgt_open <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        pos  <= '0;
        dcnt <= '0;
      end else begin
        st   <= st_nx;
        pos  <= pos_nx;
        dcnt <= dcnt_nx;
      end
    end

    // A reversal takes precedence over a coincident tick
    always_comb begin
      st_nx   = st;
      pos_nx  = pos;
      dcnt_nx = '0;
      unique case (st)
        IDLE: begin
          if (tgt_open && pos != TOP) begin
            st_nx = UP;
          end else if (!tgt_open && pos != '0) begin
            st_nx = DOWN;
          end
        end
        UP: begin
          if (!tgt_open) begin
            st_nx = DEAD;
          end else if (tick) begin
            if (pos != TOP) pos_nx = pos + 1'b1;
            if (pos >= TOP - 1'b1) st_nx = IDLE;
          end
        end
        DOWN: begin
          if (tgt_open) begin
            st_nx = DEAD;
          end else if (tick) begin
            if (pos != '0) pos_nx = pos - 1'b1;
            if (pos <= POS_W'(1)) st_nx = IDLE;
          end
        end
        DEAD: begin
          if (dcnt == DW'(DEAD_CYC - 1)) begin
            st_nx = IDLE;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        default: st_nx = IDLE;
      endcase
    end

    assign motor_up[i]    = (st == UP);
    assign motor_down[i]  = (st == DOWN);
    assign blinds_open[i] = (pos == TOP);
    assign override[i]    = ovr;
    assign position[i*POS_W +: POS_W] = pos;
  end

endmodule

// File: tb/tb_blinds_motor_controller.sv
// Directed self-checking bench for blinds_motor_controller.
// Two channels, short prescaler and travel so every scenario fits in a few hundred clocks.
module tb_blinds_motor_controller;

  localparam int NCH = 2;
  localparam int LW  = 8;
  localparam int PW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*LW-1:0] light_level;
  logic [NCH-1:0]    open_cmd;
  logic [NCH-1:0]    close_cmd;
  logic [NCH-1:0]    auto_resume;
  logic [NCH-1:0]    motor_up;
  logic [NCH-1:0]    motor_down;
  logic [NCH-1:0]    blinds_open;
  logic [NCH-1:0]    override;
  logic [NCH*PW-1:0] position;

  int checks   = 0;
  int failures = 0;

  blinds_motor_controller #(
    .NUM_CH(NCH), .LIGHT_W(LW), .OPEN_TH(160), .CLOSE_TH(96),
    .TICK_DIV(2), .TRAVEL_TICKS(4), .DEAD_CYC(3), .OVR_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .light_level(light_level),
    .open_cmd(open_cmd), .close_cmd(close_cmd),
    .auto_resume(auto_resume), .motor_up(motor_up),
    .motor_down(motor_down), .blinds_open(blinds_open),
    .override(override), .position(position)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pos(int ch);
    return int'(position[ch*PW +: PW]);
  endfunction

  task automatic set_light(int ch, int v);
    light_level[ch*LW +: LW] = LW'(v);
  endtask

  task automatic wait_pos(int ch, int p, int budget,
                          output int cyc, output bit ok);
    cyc = 0;
    while (pos(ch) != p && cyc < budget) begin
      step();
      cyc++;
    end
    ok = (pos(ch) == p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    open_cmd = '0;
    close_cmd = '0;
    auto_resume = '0;
    set_light(0, 128);
    set_light(1, 50);
    repeat (3) step();
    checks++;
    if (motor_up !== 2'b00 || motor_down !== 2'b00) begin
      failures++;
      $display("FAIL reset_motors: got up=%b dn=%b expected 00 00",
               motor_up, motor_down);
    end
    checks++;
    if (blinds_open !== 2'b00 || override !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got open=%b ovr=%b expected 00 00",
               blinds_open, override);
    end
    checks++;
    if (position !== '0) begin
      failures++;
      $display("FAIL reset_pos: got %h expected 0", position);
    end
    rst = 1'b0;
  endtask

  task automatic test_auto_open();
    int cyc;
    bit ok;
    set_light(0, 200);
    step();
    checks++;
    if (motor_up !== 2'b00) begin
      failures++;
      $display("FAIL open_lat1: got up=%b expected 00", motor_up);
    end
    step();
    checks++;
    if (motor_up !== 2'b01 || motor_down !== 2'b00) begin
      failures++;
      $display("FAIL open_lat2: got up=%b dn=%b expected 01 00",
               motor_up, motor_down);
    end
    for (int p = 1; p <= 4; p++) begin
      wait_pos(0, p, 4, cyc, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL open_pos%0d: got %0d expected %0d", p, pos(0), p);
      end
      if (p > 1) begin
        checks++;
        if (cyc != 2) begin
          failures++;
          $display("FAIL open_gap%0d: got %0d clks expected 2", p, cyc);
        end
      end
      if (p < 4) begin
        checks++;
        if (motor_up !== 2'b01) begin
          failures++;
          $display("FAIL open_run%0d: got up=%b expected 01", p, motor_up);
        end
      end
    end
    checks++;
    if (motor_up !== 2'b00 || blinds_open !== 2'b01) begin
      failures++;
      $display("FAIL open_done: got up=%b open=%b expected 00 01",
               motor_up, blinds_open);
    end
    checks++;
    if (pos(1) != 0) begin
      failures++;
      $display("FAIL open_ch1: got pos1=%0d expected 0", pos(1));
    end
  endtask

  task automatic test_hysteresis();
    int cyc;
    bit ok;
    bit moved;
    int band_hi[2] = '{120, 96};
    int band_lo[2] = '{97, 160};
    foreach (band_hi[k]) begin
      set_light(0, band_hi[k]);
      moved = 1'b0;
      repeat (8) begin
        step();
        if (motor_up[0] || motor_down[0] || pos(0) != 4) moved = 1'b1;
      end
      checks++;
      if (moved) begin
        failures++;
        $display("FAIL hold_open_%0d: got motion expected none pos=%0d",
                 band_hi[k], pos(0));
      end
    end
    set_light(0, 50);
    wait_pos(0, 0, 16, cyc, ok);
    checks++;
    if (!ok || motor_down[0] !== 1'b0) begin
      failures++;
      $display("FAIL auto_close: got pos=%0d dn=%b expected 0 0",
               pos(0), motor_down[0]);
    end
    foreach (band_lo[k]) begin
      set_light(0, band_lo[k]);
      moved = 1'b0;
      repeat (8) begin
        step();
        if (motor_up[0] || motor_down[0] || pos(0) != 0) moved = 1'b1;
      end
      checks++;
      if (moved) begin
        failures++;
        $display("FAIL hold_closed_%0d: got motion expected none pos=%0d",
                 band_lo[k], pos(0));
      end
    end
  endtask

  task automatic test_manual_reversal();
    int cyc;
    bit ok;
    bit moved;
    set_light(0, 200);
    wait_pos(0, 2, 20, cyc, ok);
    checks++;
    if (!ok || motor_up[0] !== 1'b1) begin
      failures++;
      $display("FAIL rev_reach2: got pos=%0d up=%b expected 2 1",
               pos(0), motor_up[0]);
    end
    close_cmd[0] = 1'b1;
    step();
    close_cmd[0] = 1'b0;
    set_light(0, 50);
    checks++;
    if (override[0] !== 1'b1 || motor_up[0] !== 1'b1) begin
      failures++;
      $display("FAIL rev_cmd: got ovr=%b up=%b expected 1 1",
               override[0], motor_up[0]);
    end
    step();
    checks++;
    if (motor_up[0] !== 1'b0 || motor_down[0] !== 1'b0 || pos(0) != 2) begin
      failures++;
      $display("FAIL rev_dead: got up=%b dn=%b pos=%0d expected 0 0 2",
               motor_up[0], motor_down[0], pos(0));
    end
    moved = 1'b0;
    repeat (2) begin
      step();
      if (motor_up[0] || motor_down[0]) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL rev_deadtime: got motor on expected off for 3 clks");
    end
    cyc = 0;
    while (!motor_down[0] && cyc < 3) begin
      step();
      cyc++;
    end
    checks++;
    if (motor_down[0] !== 1'b1 || motor_up[0] !== 1'b0) begin
      failures++;
      $display("FAIL rev_down: got dn=%b up=%b expected 1 0",
               motor_down[0], motor_up[0]);
    end
    wait_pos(0, 0, 16, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rev_home: got pos=%0d expected 0", pos(0));
    end
`ifndef OVERRIDE_TIMEOUT_EN
    checks++;
    if (override[0] !== 1'b1) begin
      failures++;
      $display("FAIL rev_ovr: got %b expected 1", override[0]);
    end
`endif
    auto_resume[0] = 1'b1;
    step();
    auto_resume[0] = 1'b0;
    checks++;
    if (override[0] !== 1'b0) begin
      failures++;
      $display("FAIL rev_resume: got ovr=%b expected 0", override[0]);
    end
    checks++;
    if (pos(1) != 0 || motor_up[1] || motor_down[1]) begin
      failures++;
      $display("FAIL rev_ch1: got pos1=%0d up=%b dn=%b expected 0 0 0",
               pos(1), motor_up[1], motor_down[1]);
    end
  endtask

  task automatic test_open_close_together();
    int cyc;
    bit ok;
    open_cmd[1] = 1'b1;
    close_cmd[1] = 1'b1;
    step();
    open_cmd[1] = 1'b0;
    close_cmd[1] = 1'b0;
    checks++;
    if (override[1] !== 1'b1 || motor_up[1] !== 1'b0) begin
      failures++;
      $display("FAIL both_cmd: got ovr=%b up=%b expected 1 0",
               override[1], motor_up[1]);
    end
    step();
    checks++;
    if (motor_up[1] !== 1'b1 || motor_down[1] !== 1'b0) begin
      failures++;
      $display("FAIL both_up: got up=%b dn=%b expected 1 0",
               motor_up[1], motor_down[1]);
    end
    wait_pos(1, 4, 16, cyc, ok);
    checks++;
    if (!ok || blinds_open !== 2'b10) begin
      failures++;
      $display("FAIL both_open: got pos1=%0d open=%b expected 4 10",
               pos(1), blinds_open);
    end
    checks++;
    if (pos(0) != 0 || motor_up[0] || motor_down[0]) begin
      failures++;
      $display("FAIL both_ch0: got pos0=%0d expected 0 idle", pos(0));
    end
    set_light(1, 20);
`ifndef OVERRIDE_TIMEOUT_EN
    repeat (8) step();
    checks++;
    if (pos(1) != 4 || motor_down[1] !== 1'b0 || override[1] !== 1'b1) begin
      failures++;
      $display("FAIL both_hold: got pos1=%0d dn=%b ovr=%b expected 4 0 1",
               pos(1), motor_down[1], override[1]);
    end
`endif
    auto_resume[1] = 1'b1;
    step();
    auto_resume[1] = 1'b0;
    checks++;
    if (override[1] !== 1'b0) begin
      failures++;
      $display("FAIL both_resume: got ovr=%b expected 0", override[1]);
    end
    wait_pos(1, 0, 16, cyc, ok);
    checks++;
    if (!ok || motor_down[1] !== 1'b0) begin
      failures++;
      $display("FAIL both_close: got pos1=%0d dn=%b expected 0 0",
               pos(1), motor_down[1]);
    end
  endtask

  task automatic test_override_timeout();
    int cyc;
    bit ok;
    set_light(0, 20);
    open_cmd[0] = 1'b1;
    step();
    open_cmd[0] = 1'b0;
    checks++;
    if (override[0] !== 1'b1) begin
      failures++;
      $display("FAIL tmo_cmd: got ovr=%b expected 1", override[0]);
    end
`ifdef OVERRIDE_TIMEOUT_EN
    cyc = 0;
    while (override[0] && cyc < 14) begin
      step();
      cyc++;
    end
    checks++;
    if (override[0] !== 1'b0 || cyc < 9 || cyc > 10) begin
      failures++;
      $display("FAIL tmo_expire: got ovr=%b after %0d clks expected 0 at 9..10",
               override[0], cyc);
    end
`else
    wait_pos(0, 4, 16, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_open: got pos=%0d expected 4", pos(0));
    end
    repeat (20) step();
    checks++;
    if (override[0] !== 1'b1 || pos(0) != 4) begin
      failures++;
      $display("FAIL tmo_hold: got ovr=%b pos=%0d expected 1 4",
               override[0], pos(0));
    end
    auto_resume[0] = 1'b1;
    step();
    auto_resume[0] = 1'b0;
`endif
    wait_pos(0, 0, 24, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_close: got pos=%0d expected 0", pos(0));
    end
  endtask

  task automatic test_reset_mid_move();
    int cyc;
    bit ok;
    set_light(0, 200);
    wait_pos(0, 4, 20, cyc, ok);
    set_light(0, 50);
    wait_pos(0, 3, 12, cyc, ok);
    checks++;
    if (!ok || motor_down[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstm_pre: got pos=%0d dn=%b expected 3 1",
               pos(0), motor_down[0]);
    end
    rst = 1'b1;
    step();
    checks++;
    if (motor_up !== 2'b00 || motor_down !== 2'b00 ||
        blinds_open !== 2'b00 || override !== 2'b00) begin
      failures++;
      $display("FAIL rstm_out: got up=%b dn=%b open=%b ovr=%b expected all 0",
               motor_up, motor_down, blinds_open, override);
    end
    checks++;
    if (position !== '0) begin
      failures++;
      $display("FAIL rstm_pos: got %h expected 0", position);
    end
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (motor_up !== 2'b00 || motor_down !== 2'b00 || position !== '0) begin
      failures++;
      $display("FAIL rstm_idle: got up=%b dn=%b pos=%h expected idle at 0",
               motor_up, motor_down, position);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    light_level = '0;
    test_reset();
    test_auto_open();
    test_hysteresis();
    test_manual_reversal();
    test_open_close_together();
    test_override_timeout();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
